// File: rtl/ifft_cp_sequencer.sv
// IFFT sequencer: issues the core config word, frames subcarriers into N-point frames,
// and replays each captured time-domain symbol from a ping-pong buffer with a cyclic prefix.
module ifft_cp_sequencer #(
  parameter int W      = 16,
  parameter int N_LOG2 = 3,
  parameter int CP     = 2,
  parameter int CFG_W  = 24
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [CFG_W-1:0]   cfg_word,
  input  logic               reconfig,
  input  logic [2*W-1:0]     s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [CFG_W-1:0]   cfg_tdata,
  output logic               cfg_tvalid,
  input  logic               cfg_tready,
  output logic [2*W-1:0]     core_in_tdata,
  output logic               core_in_tvalid,
  output logic               core_in_tlast,
  input  logic               core_in_tready,
  input  logic [2*W-1:0]     core_out_tdata,
  input  logic               core_out_tvalid,
  input  logic               core_out_tlast,
  output logic               core_out_tready,
  output logic [2*W-1:0]     m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [W-1:0]       m_axis_real_unsigned,
  output logic               frame_err,
  output logic [15:0]        sym_count
);

  localparam int N           = 1 << N_LOG2;
  localparam int SYM         = N + CP;
  localparam int BW          = $clog2(SYM + 1);
  localparam int RD_START_I  = (N - CP) % N;
  localparam int BEAT_LAST_I = SYM - 1;

  localparam logic [N_LOG2-1:0] IDX_LAST  = '1;
  localparam logic [N_LOG2-1:0] RD_START  = RD_START_I[N_LOG2-1:0];
  localparam logic [BW-1:0]     BEAT_LAST = BEAT_LAST_I[BW-1:0];
  localparam logic [W-1:0]      HALF      = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {ST_CFG, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   cfg_reg;
  logic               cfg_held;
  logic               reconfig_pend;
  logic               bound_hold;
  logic [N_LOG2-1:0]  in_cnt;
  logic               s_hs;

  logic [2*W-1:0]     mem [2][N];
  logic               wb, rb;
  logic [1:0]         full, full_nxt;
  logic [N_LOG2-1:0]  wr_idx, rd_addr;
  logic [BW-1:0]      rd_beat;
  logic               wr_hs, wr_last, rd_hs, rd_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_CFG;
    else          state <= state_nxt;
  end

  // A pending reconfig at a frame boundary blocks the next input beat so the boundary is always honoured.
  always_comb begin
    state_nxt      = state;
    cfg_tvalid     = 1'b0;
    s_axis_tready  = 1'b0;
    core_in_tvalid = 1'b0;
    core_in_tlast  = 1'b0;
    bound_hold     = 1'b0;
    case (state)
      ST_CFG: begin
        cfg_tvalid = 1'b1;
        if (cfg_tready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        core_in_tlast = (in_cnt == IDX_LAST);
        bound_hold    = reconfig_pend && (in_cnt == '0);
        if (bound_hold) begin
          state_nxt = ST_CFG;
        end else begin
          s_axis_tready  = core_in_tready;
          core_in_tvalid = s_axis_tvalid;
        end
      end
      default: state_nxt = ST_CFG;
    endcase
  end

  assign core_in_tdata = s_axis_tdata;
  assign cfg_tdata     = cfg_held ? cfg_reg : cfg_word;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  // Until the word is latched, cfg_tdata shows cfg_word live so the post-reset value is available at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_reg       <= '0;
      cfg_held      <= 1'b0;
      reconfig_pend <= 1'b0;
      in_cnt        <= '0;
    end else begin
      if (s_hs) in_cnt <= in_cnt + 1'b1;
      if (state == ST_CFG) begin
        if (cfg_tready) begin
          cfg_held <= 1'b0;
        end else if (!cfg_held) begin
          cfg_reg  <= cfg_word;
          cfg_held <= 1'b1;
        end
      end else if (bound_hold) begin
        cfg_reg       <= cfg_word;
        cfg_held      <= 1'b1;
        reconfig_pend <= 1'b0;
      end else if (reconfig) begin
        reconfig_pend <= 1'b1;
      end
    end
  end

  assign core_out_tready      = !full[wb];
  assign wr_hs                = core_out_tvalid && core_out_tready;
  assign wr_last              = (wr_idx == IDX_LAST);
  assign m_axis_tvalid        = full[rb];
  assign rd_hs                = m_axis_tvalid && m_axis_tready;
  assign rd_last              = (rd_beat == BEAT_LAST);
  assign m_axis_tlast         = m_axis_tvalid && rd_last;
  assign m_axis_tdata         = m_axis_tvalid ? mem[rb][rd_addr] : '0;
  assign m_axis_real_unsigned = m_axis_tdata[2*W-1:W] + HALF;

  always_ff @(posedge aclk) begin
    if (wr_hs) mem[wb][wr_idx] <= core_out_tdata;
  end

  // Writer only touches a bank that is not full, so set and clear never collide on one bank.
  always_comb begin
    full_nxt = full;
    if (rd_hs && rd_last) full_nxt[rb] = 1'b0;
    if (wr_hs && wr_last) full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wr_idx    <= '0;
      rd_addr   <= RD_START;
      rd_beat   <= '0;
      frame_err <= 1'b0;
      sym_count <= '0;
    end else begin
      full <= full_nxt;
      if (wr_hs) begin
        if (core_out_tlast != wr_last) frame_err <= 1'b1;
        if (wr_last) begin
          wr_idx <= '0;
          wb     <= ~wb;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      // Prefix beats walk N-CP..N-1 and wrap naturally into 0..N-1.
      if (rd_hs) begin
        if (rd_last) begin
          rd_beat   <= '0;
          rd_addr   <= RD_START;
          rb        <= ~rb;
          sym_count <= sym_count + 1'b1;
        end else begin
          rd_beat <= rd_beat + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ifft_cp_sequencer.md
# ifft_cp_sequencer

Parametrised IFFT front/back-end sequencer for the OFDM transmit chain. It issues and re-issues the FFT core configuration word, frames the upstream subcarrier stream into N-point IFFT frames with generated `tlast`, and captures the core's time-domain output in a ping-pong buffer. It emits each symbol with a CP-sample cyclic prefix, plus an offset-binary real output for the DAC. It sits between the QAM mapper and the DAC interface and wraps an external FFT core instance.

## Interface
- `W`, 16: component width; samples are 2W bits, {real[2W-1:W], imag[W-1:0]}.
- `N_LOG2`, 3: log2 of IFFT points, N = 2^N_LOG2; legal range 2..10.
- `CP`, 2: cyclic-prefix length; legal range 0..N.
- `CFG_W`, 24: width of the core config word.

Ports:
- `aclk`  in  1  single clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cfg_word`  in  CFG_W  config word; sampled when a config transfer starts.
- `reconfig`  in  1  one-cycle pulse; requests re-issue of the config word.
- `s_axis_tdata`/`s_axis_tvalid`/`s_axis_tready`  in/in/out  2W/1/1  subcarrier input.
- `cfg_tdata`/`cfg_tvalid`/`cfg_tready`  out/out/in  CFG_W/1/1  to core config port.
- `core_in_tdata`/`core_in_tvalid`/`core_in_tlast`/`core_in_tready`  out/out/out/in  2W/1/1/1  to core data input.
- `core_out_tdata`/`core_out_tvalid`/`core_out_tlast`/`core_out_tready`  in/in/in/out  2W/1/1/1  from core data output.
- `m_axis_tdata`/`m_axis_tvalid`/`m_axis_tlast`/`m_axis_tready`  out/out/out/in  2W/1/1/1  CP-extended symbol stream.
- `m_axis_real_unsigned`  out  W  `m_axis_tdata[2W-1:W]` + 2^(W-1), modulo 2^W.
- `frame_err`  out  1  sticky; core output `tlast` misaligned.
- `sym_count`  out  16  count of completed output symbols, wraps.

## Operation
- Input FSM states: CFG and RUN. Reset state is CFG.
  - CFG: `cfg_tvalid`=1 and `cfg_tdata` = latched `cfg_word`; `s_axis_tready`=0. Move to RUN on the `cfg_tready` handshake.
  - RUN: combinational pass-through, with `core_in_*` = `s_axis_*` and `s_axis_tready` = `core_in_tready`. `in_cnt` increments per handshake and wraps at N. `core_in_tlast` = (`in_cnt`==N-1).
- `reconfig` sets a sticky pending flag. The pending flag is honoured only at a frame boundary (`in_cnt`==0 with no handshake in that cycle), where the FSM enters CFG and re-latches `cfg_word`.
  - A `reconfig` arriving mid-frame waits for that frame's last handshake.
  - A `reconfig` arriving during CFG is absorbed; no second transfer is issued.
- Output buffer: two banks of N×2W registers, write bank `wb`, read bank `rb`, flags `full[1:0]`.
  - `core_out_tready` = !`full[wb]`. Each handshake writes `mem[wb][wr_idx]`.
  - On the write at `wr_idx`==N-1: set `full[wb]`, toggle `wb`, zero `wr_idx`. `wr_idx` is authoritative.
  - `frame_err` sets if `core_out_tlast` != (`wr_idx`==N-1) on any handshake.
- Read sequencer: while `full[rb]`, `m_axis_tvalid`=1. Read order is indices N-CP..N-1, then 0..N-1, for N+CP beats. `m_axis_tlast` is on the final beat.
  - On the final handshake: clear `full[rb]`, toggle `rb`, increment `sym_count`.
  - CP=0 gives plain N-beat framing.
- `m_axis_tdata` = `mem[rb][rd_addr]`, where `rd_addr` is registered. It is held stable while `tvalid` && !`tready`.

## Timing
- Reset values:
  - `cfg_tvalid`=1; `cfg_tdata`=`cfg_word` as sampled at reset release.
  - `s_axis_tready`=0, `core_in_tvalid`=0, `core_in_tlast`=0.
  - `core_out_tready`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_real_unsigned`=16'h8000 (for W=16).
  - `frame_err`=0, `sym_count`=0; all counters, flags and `wb`/`rb` cleared.
- Reset mid-operation: abandon all frames immediately; buffer contents are don't-care; FSM returns to CFG.
- Input path latency: 0 cycles (combinational).
- Output: `m_axis_tvalid` rises 1 cycle after the edge that writes sample N-1. Back-to-back symbols run with no gap when the other bank is already full.
- Bank freed and written in the same cycle: the clear takes effect at that edge. The writer sees `core_out_tready`=1 the next cycle; there is no bypass.
- Both banks full: `core_out_tready`=0 until the current read's final handshake.
- Sustained rate: N input beats per N+CP output beats. Upstream throttling comes via core backpressure.

## Test plan
- Reset release with `cfg_tready` held 0 for 3 cycles → `cfg_tvalid` stays 1. When `cfg_tready`=1, transfer completes, `cfg_tvalid`=0 next cycle, `s_axis_tready` follows `core_in_tready`.
- N=8, CP=2, core loopback of input 0..7 → `core_in_tlast` on the 8th beat. Output is 6,7,0,1,…,7 (10 beats), `tlast` on beat 10, `sym_count`=1.
- Three frames streamed with `m_axis_tready` toggling 1-0-1 → no data lost or reordered. `core_out_tready`=0 while both banks are full, and `tdata` is stable during stalls.
- `reconfig` pulse at `in_cnt`=3 → frame finishes (8 beats). Then CFG is entered, `cfg_tvalid`=1 with the new `cfg_word`, and `s_axis_tready`=0 until the handshake.
- Core output `tlast` injected on the 5th beat → `frame_err`=1 and stays 1. Framing still follows the counter (10-beat symbol).
- Output real = 16'hFFFF → `m_axis_real_unsigned`=16'h7FFF. Assert `aresetn` mid-symbol → all outputs return to their reset values.
